gpr_scoreboard_regfile: RTL and testbench
=========================================

Name: gpr_scoreboard_regfile

Overview:
- Parametrised successor to the core's single-write GPR file.
- Adds NWR writeback ports, NRD read ports with same-cycle write bypass, and a per-register busy scoreboard that gates issue.
- Sits between the IDU (read and issue) and the WBU/LSU writeback paths.
- Gives the pipeline RAW/WAW hazard detection without a separate hazard unit.

Parameters:
- XLEN, 64, register data width.
- NREG, 32, number of architectural registers; register 0 is hard-wired to zero.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; a higher index has higher priority.
- BYPASS, 1, when 1, same-cycle write data is forwarded to the read ports.
- AW, $clog2(NREG), register address width (derived, not overridable).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses, port k in bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- wb_valid  in  NWR  per-port write strobe.
- wb_addr  in  NWR*AW  write addresses.
- wb_data  in  NWR*XLEN  write data.
- iss_valid  in  1  IDU has an instruction to issue.
- iss_rs1  in  AW  source register 1 of the issuing instruction.
- iss_rs2  in  AW  source register 2 of the issuing instruction.
- iss_use  in  2  bit0: rs1 is used; bit1: rs2 is used.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_wen  in  1  issuing instruction writes iss_rd.
- iss_ready  out  1  issue permitted this cycle (combinational).
- flush  in  1  pipeline flush; clears all busy bits.
- busy_vec  out  NREG  scoreboard state, registered.
- dbg_addr  in  AW  difftest/debug read address.
- dbg_data  out  XLEN  debug read data; never bypassed.

Behaviour:
- Reset (reset=0, asynchronous): all registers 0; busy_vec 0.
  - Outputs during reset: rd_data=0, iss_ready=1 when iss_valid=1.
- Register 0:
  - Writes to register 0 are dropped.
  - Reads of register 0 return 0.
  - Register 0 is never marked busy.
- Write:
  - On a clock edge, for each port with wb_valid[i]=1 and wb_addr≠0, the register takes wb_data.
  - Same address on several ports: the highest-index port wins.
- Read (combinational):
  - With BYPASS=1, a read whose address matches a valid write port this cycle returns that port's wb_data, using the same priority rule.
  - Otherwise the read returns the stored value.
  - With BYPASS=0, a read never sees same-cycle write data.
- iss_fire = iss_valid & iss_ready.
- iss_ready is 1 when all of the following hold:
  - rs1 is clear: iss_use[0]=0, or busy[rs1]=0, or (BYPASS=1 and any write port targets rs1 this cycle).
  - rs2 is clear, by the same rule.
  - rd is clear: iss_wen=0, or busy[rd]=0, or any write port targets rd this cycle (WAW resolves in the same cycle).
- Busy update per register r, in priority order:
  1. flush=1: busy[r] becomes 0 for every r, overriding everything else, including a simultaneous iss_fire.
  2. iss_fire with iss_wen=1 and iss_rd=r≠0: busy[r] becomes 1. Set beats clear, because the older writer is retiring in the same cycle.
  3. Any wb_valid with wb_addr=r: busy[r] becomes 0.
  4. Otherwise busy[r] holds.
- Writes that arrive after a flush still update the register data; they are harmless stale values.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Latency:
  - Data written at edge N is visible from the array at N+1.
  - With BYPASS=1, the same data is also visible on rd_data during cycle N.
- dbg_data = stored value of dbg_addr.
- Reset asserted mid-operation clears all state immediately. In-flight writeback strobes are ignored while reset=0.

Decomposition:
- Shared package:
  - XLEN and NREG defaults.
  - Register-index typedef (AW bits).
  - Function prio_match(addr, wb_valid, wb_addr) returning hit and the winning port index. It is reused by the write path, the bypass, and the ready logic.
- One natural sub-module, regfile_scoreboard: busy bits, set/clear/flush logic, iss_ready.
- The data array plus bypass stays in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  -> busy_vec=0; rd_data=0 for every address; iss_ready=1.
- Write then read: wb0 writes x5=0xDEADBEEF_00000001.
  -> rd_data[0]=that value in the same cycle (BYPASS=1) and from the array next cycle.
  -> With BYPASS=0, the same-cycle read returns 0.
- Port priority and register 0:
  - wb0 and wb1 both target x7, data 0x11 and 0x22 -> x7=0x22.
  - wb1 writes x0=0xFF -> a later read of x0 returns 0.
- RAW stall:
  - Issue with rd=x3; next cycle issue with rs1=x3 -> iss_ready=0 until wb writes x3.
  - In the writeback cycle -> iss_ready=1 and rd_data carries the bypassed value.
- Simultaneous set and clear: wb clears x4 while a new iss_fire targets x4.
  -> busy[4]=1 after the edge.
- Flush: with x3, x4 and x9 busy, assert flush together with iss_fire to x10.
  -> busy_vec=0 after the edge; a later writeback to x3 updates the data and busy stays 0.

Source files
------------

// File: rtl/gpr_scoreboard_regfile_pkg.sv
// Shared types and the write-port priority matcher used by the data array,
// the read bypass and the issue-ready logic.
package gpr_scoreboard_regfile_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int MAX_WR   = 8;
  localparam int MAX_AW   = 8;
  localparam int WIDX_W   = $clog2(MAX_WR);

  typedef logic [$clog2(NREG_DEF)-1:0] gpr_idx_t;

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } prio_t;

  // Ascending scan so the highest-index matching port is the one left in idx.
  function automatic prio_t prio_match(input logic [MAX_AW-1:0]             addr,
                                       input logic [MAX_WR-1:0]             vld,
                                       input logic [MAX_WR-1:0][MAX_AW-1:0] wa);
    prio_t m;
    m = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (vld[i] && (wa[i] == addr)) begin
        m.hit = 1'b1;
        m.idx = WIDX_W'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/gpr_scoreboard_regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on writeback, flush wipes all;
// produces the combinational issue-ready.
module regfile_scoreboard
  import gpr_scoreboard_regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG_DEF),
  parameter int BYPASS = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [MAX_WR-1:0]                i_wb_vld,
  input  logic [MAX_WR-1:0][MAX_AW-1:0]    i_wb_addr,
  input  logic                             i_iss_valid,
  input  logic [AW-1:0]                    i_iss_rs1,
  input  logic [AW-1:0]                    i_iss_rs2,
  input  logic [1:0]                       i_iss_use,
  input  logic [AW-1:0]                    i_iss_rd,
  input  logic                             i_iss_wen,
  input  logic                             i_flush,
  output logic                             o_iss_ready,
  output logic [NREG-1:0]                  o_busy_vec
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  prio_t           w_m_rs1, w_m_rs2, w_m_rd;
  logic            w_rs1_ok, w_rs2_ok, w_rd_ok, w_fire;

  assign w_m_rs1 = prio_match(MAX_AW'(i_iss_rs1), i_wb_vld, i_wb_addr);
  assign w_m_rs2 = prio_match(MAX_AW'(i_iss_rs2), i_wb_vld, i_wb_addr);
  assign w_m_rd  = prio_match(MAX_AW'(i_iss_rd),  i_wb_vld, i_wb_addr);

  // Sources only clear early when the value can actually be forwarded;
  // a destination clears on any same-cycle write since WAW retires in order.
  assign w_rs1_ok = !i_iss_use[0] || !r_busy[i_iss_rs1] || ((BYPASS != 0) && w_m_rs1.hit);
  assign w_rs2_ok = !i_iss_use[1] || !r_busy[i_iss_rs2] || ((BYPASS != 0) && w_m_rs2.hit);
  assign w_rd_ok  = !i_iss_wen    || !r_busy[i_iss_rd]  || w_m_rd.hit;

  assign o_iss_ready = w_rs1_ok && w_rs2_ok && w_rd_ok;
  assign w_fire      = i_iss_valid && o_iss_ready;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREG; r++) begin
      if (i_flush)
        w_busy_nxt[r] = 1'b0;
      else if (w_fire && i_iss_wen && (i_iss_rd == AW'(r)))
        w_busy_nxt[r] = 1'b1;
      else if (prio_match(MAX_AW'(r), i_wb_vld, i_wb_addr).hit)
        w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/gpr_scoreboard_regfile.sv
// Multi-port GPR file with same-cycle write bypass and an issue-gating busy scoreboard.
module gpr_scoreboard_regfile
  import gpr_scoreboard_regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREG   = NREG_DEF,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       wb_valid,
  input  logic [NWR*AW-1:0]    wb_addr,
  input  logic [NWR*XLEN-1:0]  wb_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rs1,
  input  logic [AW-1:0]        iss_rs2,
  input  logic [1:0]           iss_use,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 iss_wen,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);

  logic [NREG-1:0][XLEN-1:0]     r_regs;
  logic [MAX_WR-1:0]             w_wv;
  logic [MAX_WR-1:0][MAX_AW-1:0] w_wa;
  logic [MAX_WR-1:0][XLEN-1:0]   w_wd;
  prio_t                         w_wr_m [NREG];
  prio_t                         w_rd_m [NRD];

  // Strobes are masked by reset so nothing leaks through the bypass while held.
  always_comb begin
    w_wv = '0;
    w_wa = '0;
    w_wd = '0;
    for (int i = 0; i < NWR; i++) begin
      w_wv[i]         = wb_valid[i] & reset;
      w_wa[i][AW-1:0] = wb_addr[i*AW +: AW];
      w_wd[i]         = wb_data[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      w_wr_m[r] = prio_match(MAX_AW'(r), w_wv, w_wa);
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (w_wr_m[r].hit) r_regs[r] <= w_wd[w_wr_m[r].idx];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rd_m[k] = prio_match(MAX_AW'(rd_addr[k*AW +: AW]), w_wv, w_wa);
      if (rd_addr[k*AW +: AW] == '0)
        rd_data[k*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && w_rd_m[k].hit)
        rd_data[k*XLEN +: XLEN] = w_wd[w_rd_m[k].idx];
      else
        rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
    end
  end

  assign dbg_data = r_regs[dbg_addr];

  regfile_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .i_wb_vld    (w_wv),
    .i_wb_addr   (w_wa),
    .i_iss_valid (iss_valid),
    .i_iss_rs1   (iss_rs1),
    .i_iss_rs2   (iss_rs2),
    .i_iss_use   (iss_use),
    .i_iss_rd    (iss_rd),
    .i_iss_wen   (iss_wen),
    .i_flush     (flush),
    .o_iss_ready (iss_ready),
    .o_busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_gpr_scoreboard_regfile.sv
// Randomized and directed bench for gpr_scoreboard_regfile against a behavioural model.
module tb_gpr_scoreboard_regfile;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0][4:0]  ra;
  logic [1:0]       wbv;
  logic [1:0][4:0]  wba;
  logic [1:0][63:0] wbd;
  logic             issv, wen, flush;
  logic [4:0]       rs1, rs2, rd, dbga;
  logic [1:0]       use_;
  logic [127:0]     rdd, rdd_nb;
  logic             ready, ready_nb;
  logic [31:0]      busy, busy_nb;
  logic [63:0]      dbgd, dbgd_nb;

  logic [63:0] mem [32];
  logic [31:0] mbusy;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gpr_scoreboard_regfile #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rd_addr(ra), .rd_data(rdd),
    .wb_valid(wbv), .wb_addr(wba), .wb_data(wbd),
    .iss_valid(issv), .iss_rs1(rs1), .iss_rs2(rs2), .iss_use(use_),
    .iss_rd(rd), .iss_wen(wen), .iss_ready(ready), .flush(flush),
    .busy_vec(busy), .dbg_addr(dbga), .dbg_data(dbgd));

  gpr_scoreboard_regfile #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(ra), .rd_data(rdd_nb),
    .wb_valid(wbv), .wb_addr(wba), .wb_data(wbd),
    .iss_valid(issv), .iss_rs1(rs1), .iss_rs2(rs2), .iss_use(use_),
    .iss_rd(rd), .iss_wen(wen), .iss_ready(ready_nb), .flush(flush),
    .busy_vec(busy_nb), .dbg_addr(dbga), .dbg_data(dbgd_nb));

  function automatic bit wtargets(input logic [4:0] a);
    for (int i = 0; i < 2; i++) if (wbv[i] && wba[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] a, input bit byp);
    if (a == 0) return 64'h0;
    if (byp) for (int i = 1; i >= 0; i--) if (wbv[i] && wba[i] == a) return wbd[i];
    return mem[a];
  endfunction

  function automatic bit mready();
    bit s1, s2, d;
    s1 = !use_[0] || !mbusy[rs1] || wtargets(rs1);
    s2 = !use_[1] || !mbusy[rs2] || wtargets(rs2);
    d  = !wen || !mbusy[rd] || wtargets(rd);
    return s1 && s2 && d;
  endfunction

  task automatic idle();
    wbv = 2'b00; wba = '0; wbd = '0; issv = 0; wen = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0; use_ = 2'b00; ra = '0; dbga = 0;
  endtask

  // Advance one clock; model next-state is taken from the inputs before the edge.
  task automatic cycle();
    logic [63:0] nmem [32];
    logic [31:0] nb;
    bit fire;
    fire = issv && mready();
    nmem = mem;
    for (int i = 0; i < 2; i++) if (wbv[i] && wba[i] != 0) nmem[wba[i]] = wbd[i];
    nb = mbusy;
    for (int i = 0; i < 2; i++) if (wbv[i]) nb[wba[i]] = 1'b0;
    if (fire && wen && rd != 0) nb[rd] = 1'b1;
    if (flush) nb = '0;
    nb[0] = 1'b0;
    @(posedge clock); #1;
    mem = nmem; mbusy = nb;
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle();
    issv = 1; wen = 1; rd = 5'd3;
    wbv = 2'b11; wba[0] = 5'd5; wba[1] = 5'd6;
    wbd[0] = {$urandom, $urandom}; wbd[1] = {$urandom, $urandom};
    repeat (3) @(negedge clock);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a); #1;
      checks++;
      if (rdd !== 128'h0) begin errors++; $display("FAIL reset_rd addr %0d got %h exp 0", a, rdd); end
      checks++;
      if (rdd_nb !== 128'h0) begin errors++; $display("FAIL reset_rd_nb addr %0d got %h exp 0", a, rdd_nb); end
    end
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    idle();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL post_reset_busy got %h exp 0", busy); end
  endtask

  task automatic test_write_read();
    idle();
    wbv = 2'b01; wba[0] = 5'd5; wbd[0] = 64'hDEADBEEF_00000001; ra[0] = 5'd5; #1;
    checks++;
    if (rdd[63:0] !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL wr_bypass got %h exp %h", rdd[63:0], 64'hDEADBEEF_00000001); end
    checks++;
    if (rdd_nb[63:0] !== 64'h0) begin errors++; $display("FAIL wr_nobypass got %h exp 0", rdd_nb[63:0]); end
    cycle();
    wbv = 2'b00; #1;
    checks++;
    if (rdd[63:0] !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL wr_array got %h exp %h", rdd[63:0], 64'hDEADBEEF_00000001); end
    checks++;
    if (rdd_nb[63:0] !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL wr_array_nb got %h exp %h", rdd_nb[63:0], 64'hDEADBEEF_00000001); end
  endtask

  task automatic test_priority_x0();
    idle();
    wbv = 2'b11; wba[0] = 5'd7; wba[1] = 5'd7; wbd[0] = 64'h11; wbd[1] = 64'h22; ra[0] = 5'd7; #1;
    checks++;
    if (rdd[63:0] !== 64'h22) begin errors++; $display("FAIL prio_bypass got %h exp 22", rdd[63:0]); end
    cycle();
    wbv = 2'b10; wba[1] = 5'd0; wbd[1] = 64'hFF; ra[1] = 5'd0; #1;
    checks++;
    if (rdd[127:64] !== 64'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rdd[127:64]); end
    cycle();
    idle(); ra[0] = 5'd7; ra[1] = 5'd0; dbga = 5'd7; #1;
    checks++;
    if (rdd[63:0] !== 64'h22) begin errors++; $display("FAIL prio_array got %h exp 22", rdd[63:0]); end
    checks++;
    if (rdd[127:64] !== 64'h0) begin errors++; $display("FAIL x0_array got %h exp 0", rdd[127:64]); end
    checks++;
    if (dbgd !== 64'h22) begin errors++; $display("FAIL dbg_x7 got %h exp 22", dbgd); end
  endtask

  task automatic test_raw_stall();
    idle();
    issv = 1; wen = 1; rd = 5'd3; #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready got %b exp 1", ready); end
    cycle();
    checks++;
    if (busy[3] !== 1'b1) begin errors++; $display("FAIL raw_busy_set got %b exp 1", busy[3]); end
    wen = 0; rd = 0; rs1 = 5'd3; use_ = 2'b01; #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", ready); end
    cycle(); #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL raw_stall2 got %b exp 0", ready); end
    wbv = 2'b01; wba[0] = 5'd3; wbd[0] = 64'hABCD; ra[0] = 5'd3; #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b exp 1", ready); end
    checks++;
    if (rdd[63:0] !== 64'hABCD) begin errors++; $display("FAIL raw_wb_data got %h exp abcd", rdd[63:0]); end
    checks++;
    if (ready_nb !== 1'b0) begin errors++; $display("FAIL raw_nb_stall got %b exp 0", ready_nb); end
    cycle();
    checks++;
    if (busy !== mbusy || busy[3] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr got %h exp %h", busy, mbusy); end
  endtask

  task automatic test_set_clear();
    idle();
    issv = 1; wen = 1; rd = 5'd4;
    cycle();
    wbv = 2'b01; wba[0] = 5'd4; wbd[0] = 64'h44; #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL setclr_ready got %b exp 1", ready); end
    cycle();
    checks++;
    if (busy[4] !== 1'b1 || busy !== mbusy) begin errors++; $display("FAIL setclr_busy got %h exp %h", busy, mbusy); end
  endtask

  task automatic test_flush();
    idle();
    issv = 1; wen = 1; rd = 5'd3; cycle();
    rd = 5'd9; cycle();
    checks++;
    if (busy !== 32'h0000_0218) begin errors++; $display("FAIL flush_pre got %h exp 00000218", busy); end
    flush = 1; rd = 5'd10; cycle();
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp 0", busy); end
    idle(); wbv = 2'b10; wba[1] = 5'd3; wbd[1] = 64'h3333; cycle();
    wbv = 2'b00; ra[0] = 5'd3; #1;
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL flush_wb_busy got %h exp 0", busy); end
    checks++;
    if (rdd[63:0] !== 64'h3333) begin errors++; $display("FAIL flush_wb_data got %h exp 3333", rdd[63:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      issv = 1'($urandom_range(0, 1)); wen = 1'($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      use_ = 2'($urandom); flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 2; i++) begin
        wbv[i] = ($urandom_range(0, 3) == 0); wba[i] = 5'($urandom_range(0, 7)); wbd[i] = {$urandom, $urandom};
        ra[i] = 5'($urandom_range(0, 7));
      end
      dbga = 5'($urandom_range(0, 7)); #1;
      checks++;
      if (rdd[63:0] !== mread(ra[0], 1)) begin errors++; $display("FAIL rnd_rd0 n=%0d got %h exp %h", n, rdd[63:0], mread(ra[0], 1)); end
      checks++;
      if (rdd[127:64] !== mread(ra[1], 1)) begin errors++; $display("FAIL rnd_rd1 n=%0d got %h exp %h", n, rdd[127:64], mread(ra[1], 1)); end
      checks++;
      if (rdd_nb[63:0] !== mread(ra[0], 0)) begin errors++; $display("FAIL rnd_rd0_nb n=%0d got %h exp %h", n, rdd_nb[63:0], mread(ra[0], 0)); end
      checks++;
      if (ready !== mready()) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, ready, mready()); end
      checks++;
      if (dbgd !== mem[dbga]) begin errors++; $display("FAIL rnd_dbg n=%0d got %h exp %h", n, dbgd, mem[dbga]); end
      cycle();
      checks++;
      if (busy !== mbusy) begin errors++; $display("FAIL rnd_busy n=%0d got %h exp %h", n, busy, mbusy); end
    end
  endtask

  task automatic test_async_reset();
    idle();
    issv = 1; wen = 1; rd = 5'd6; wbv = 2'b01; wba[0] = 5'd2; wbd[0] = 64'h5A5A; cycle();
    idle(); dbga = 5'd2; #2;
    reset = 1'b0; #1;
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL async_rst_busy got %h exp 0", busy); end
    checks++;
    if (dbgd !== 64'h0) begin errors++; $display("FAIL async_rst_dbg got %h exp 0", dbgd); end
    for (int r = 0; r < 32; r++) mem[r] = 64'h0;
    mbusy = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = 64'h0;
    mbusy = '0;
    idle();
    @(negedge clock);
    test_reset();
    test_write_read();
    test_priority_x0();
    test_raw_stall();
    test_set_clear();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
